// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state type for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ArbMaxStreak = 4;
  localparam int unsigned ArbStreakW   = 3;
  localparam int unsigned MemWordAw    = 10;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant: D is preferred unless I has waited through MAX_STREAK D grants.
module mem_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = ArbMaxStreak,
  parameter int unsigned STREAK_W   = ArbStreakW
) (
  input  logic                i_ireq,
  input  logic                i_dreq,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_gnt_d,
  output logic                o_gnt_i
);

  localparam logic [STREAK_W-1:0] LpMax = STREAK_W'(MAX_STREAK);

  logic w_force_i;

  always_comb begin
    w_force_i = i_ireq && (i_streak == LpMax);
    o_gnt_d   = i_dreq && !w_force_i;
    o_gnt_i   = i_ireq && !o_gnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fixed IDLE/SETUP/ACCESS/RESP sequence per access,
// one strobe per access, registered read data and done pulses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = ArbMaxStreak,
  parameter int unsigned STREAK_W   = ArbStreakW
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        addr_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [STREAK_W-1:0] LpMax = STREAK_W'(MAX_STREAK);

  arb_state_e          r_state, w_state_next;
  logic                w_gnt_d, w_gnt_i, w_grant;
  logic [31:0]         w_sel_addr;
  logic                r_win_d, r_we, r_hi_addr;
  logic [31:0]         r_mem_addr, r_mem_din, r_i_rdata, r_d_rdata;
  logic [STREAK_W-1:0] r_streak;
  logic                r_i_done, r_d_done, r_addr_err;

  mem_arb_select #(
    .MAX_STREAK (MAX_STREAK),
    .STREAK_W   (STREAK_W)
  ) u_select (
    .i_ireq   (i_req),
    .i_dreq   (d_req),
    .i_streak (r_streak),
    .o_gnt_d  (w_gnt_d),
    .o_gnt_i  (w_gnt_i)
  );

  always_comb begin
    w_grant      = (r_state == StIdle) && (w_gnt_d || w_gnt_i);
    w_sel_addr   = w_gnt_d ? d_addr : i_addr;
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_grant) w_state_next = StSetup;
      StSetup:  w_state_next = StAccess;
      StAccess: w_state_next = StResp;
      StResp:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win_d    <= 1'b0;
      r_we       <= 1'b0;
      r_hi_addr  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_streak   <= '0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      r_addr_err <= 1'b0;
      if (w_grant) begin
        r_win_d    <= w_gnt_d;
        r_we       <= w_gnt_d && d_we;
        // Memory only decodes the low word-address bits; high bits just flag an error.
        r_mem_addr <= {{(32 - MemWordAw){1'b0}}, w_sel_addr[MemWordAw-1:0]};
        r_hi_addr  <= |w_sel_addr[31:MemWordAw];
        r_mem_din  <= w_gnt_d ? d_wdata : 32'h0;
        if (w_gnt_d && i_req) r_streak <= (r_streak == LpMax) ? r_streak : r_streak + 1'b1;
        else                  r_streak <= '0;
      end
      if (r_state == StAccess) begin
        r_i_done   <= !r_win_d;
        r_d_done   <= r_win_d;
        r_addr_err <= r_hi_addr;
        if (!r_we) begin
          if (r_win_d) r_d_rdata <= mem_dout;
          else         r_i_rdata <= mem_dout;
        end
      end
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign mem_ren  = (r_state == StAccess) && !r_we;
  assign mem_wen  = (r_state == StAccess) && r_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign i_done   = r_i_done;
  assign d_done   = r_d_done;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, directed and random traffic.
module tb_mem_port_arbiter;

  localparam int MaxStreak = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_done, d_done, addr_err, mem_ren, mem_wen;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;

  logic [31:0] tb_mem  [1024];
  logic [31:0] ref_mem [1024];

  int checks = 0, failures = 0;
  int m_phase, m_streak, m_grants, n_done, n_overlap;
  bit m_win_d, m_we, m_err;
  logic [31:0] m_addr, m_din, m_i_rdata, m_d_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_done   (i_done),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .addr_err (addr_err),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // Level-sensitive memory: data only visible while ren is high.
  assign mem_dout = mem_ren ? tb_mem[mem_addr[9:0]] : 32'h0;
  always @(posedge clock) if (mem_wen) tb_mem[mem_addr[9:0]] <= mem_din;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_streak = 0; m_win_d = 0; m_we = 0; m_err = 0;
    m_addr = 0; m_din = 0; m_i_rdata = 0; m_d_rdata = 0;
  endtask

  task automatic check_cycle(input string tag);
    logic [159:0] o, e;
    o = {27'd0, mem_ren, mem_wen, i_done, d_done, addr_err, mem_addr, mem_din, i_rdata, d_rdata};
    e = {27'd0, m_phase == 2 && !m_we, m_phase == 2 && m_we, m_phase == 3 && !m_win_d,
         m_phase == 3 && m_win_d, m_phase == 3 && m_err, m_addr, m_din, m_i_rdata, m_d_rdata};
    check(tag, o, e);
  endtask

  // One clock: sample requests, advance the transaction model, then compare all outputs.
  task automatic tick();
    bit s_i, s_d, s_we, give_d;
    logic [31:0] s_ia, s_da, s_wd, a;
    s_i = i_req; s_d = d_req; s_we = d_we; s_ia = i_addr; s_da = d_addr; s_wd = d_wdata;
    @(posedge clock);
    if (reset) model_reset();
    else begin
      case (m_phase)
        0: if (s_d || s_i) begin
          give_d = s_d && !(s_i && m_streak == MaxStreak);
          if (give_d && s_i) m_streak = (m_streak < MaxStreak) ? m_streak + 1 : MaxStreak;
          else m_streak = 0;
          a = give_d ? s_da : s_ia;
          m_win_d = give_d;
          m_we = give_d && s_we;
          m_addr = a % 1024;
          m_err = (a >= 1024);
          m_din = give_d ? s_wd : 32'h0;
          m_grants++;
          m_phase = 1;
        end
        1: m_phase = 2;
        2: begin
          if (m_we) ref_mem[m_addr[9:0]] = m_din;
          else if (m_win_d) m_d_rdata = ref_mem[m_addr[9:0]];
          else m_i_rdata = ref_mem[m_addr[9:0]];
          m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
    #1;
    if (mem_ren && mem_wen) n_overlap++;
    if (i_done) n_done++;
    if (d_done) n_done++;
    check_cycle("cycle");
  endtask

  task automatic wait_done(input bit want_d, input int bound,
                           output int cyc, output int rens, output int wens);
    cyc = 0; rens = 0; wens = 0;
    for (int k = 0; k < bound; k++) begin
      tick();
      cyc++;
      rens += int'(mem_ren);
      wens += int'(mem_wen);
      if (want_d ? d_done : i_done) return;
    end
    checks++;
    failures++;
    $error("FAIL timeout observed=no_done_after_%0d expected=done", bound);
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 0; d_req = 0;
    #1;
    model_reset();
    check_cycle("reset_state");
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
  endfunction

  initial begin
    int cyc, rens, wens, got, dn0;
    logic [31:0] w;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; reset = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    do_reset();

    // 1: single fetch, latency and data
    tb_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    i_req = 1; i_addr = 32'h10;
    wait_done(0, 8, cyc, rens, wens);
    i_req = 0;
    check("t1_latency", 160'(cyc), 160'(3));
    check("t1_rdata", 160'(i_rdata), 160'(32'hDEADBEEF));
    check("t1_ren_cycles", 160'(rens), 160'(1));
    tick();

    // 2: store then load back
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
    wait_done(1, 8, cyc, rens, wens);
    d_req = 0;
    check("t2_wen_cycles", 160'({rens[7:0], wens[7:0]}), 160'(16'h0001));
    check("t2_addr_held", 160'(mem_addr), 160'(32'h20));
    tick();
    d_req = 1; d_we = 0;
    wait_done(1, 8, cyc, rens, wens);
    d_req = 0;
    check("t2_load", 160'(d_rdata), 160'(32'h12345678));
    tick();

    // 3: both held high, starvation bound
    do_reset();
    i_req = 1; d_req = 1; d_we = 0;
    i_addr = 32'($urandom_range(0, 1023)); d_addr = 32'($urandom_range(0, 1023));
    for (int k = 0; k < 10; k++) begin
      got = 0;
      for (int c = 0; c < 8 && got == 0; c++) begin
        tick();
        if (i_done || d_done) got = 1;
      end
      check($sformatf("t3_grant%0d", k), 160'({got[0], d_done}), 160'({1'b1, (k % 5) != 4}));
    end
    i_req = 0; d_req = 0;
    tick(); tick();

    // 4: out-of-range address wraps and flags
    w = $urandom; tb_mem[0] = w; ref_mem[0] = w;
    d_req = 1; d_we = 0; d_addr = 32'h400;
    wait_done(1, 8, cyc, rens, wens);
    d_req = 0;
    check("t4_err_with_done", 160'({addr_err, d_done}), 160'(2'b11));
    check("t4_mem_addr", 160'(mem_addr), 160'(0));
    check("t4_rdata", 160'(d_rdata), 160'(w));
    tick();
    check("t4_err_pulse", 160'(addr_err), 160'(0));

    // 5: reset during a store's strobe
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = $urandom;
    tick(); tick();
    check("t5_in_access", 160'(mem_wen), 160'(1));
    d_req = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("t5_wen_drop", 160'(mem_wen), 160'(0));
    check_cycle("t5_reset_outputs");
    dn0 = n_done;
    tick(); tick();
    reset = 1'b0;
    check("t5_no_done", 160'(n_done), 160'(dn0));
    i_req = 1; i_addr = 32'h11;
    wait_done(0, 8, cyc, rens, wens);
    i_req = 0;
    check("t5_fetch_latency", 160'(cyc), 160'(3));
    check("t5_fetch_data", 160'(i_rdata), 160'(ref_mem[17]));
    tick();

    // 6: random traffic
    do_reset();
    m_grants = 0; n_done = 0; n_overlap = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (i_done) i_req = 0;
      if (d_done) d_req = 0;
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = rand_addr();
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom;
      end
    end
    i_req = 0; d_req = 0;
    repeat (6) tick();
    check("t6_done_vs_grant", 160'(n_done), 160'(m_grants));
    check("t6_no_overlap", 160'(n_overlap), 160'(0));
    check("t6_activity", 160'(m_grants > 100), 160'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
